// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature velocity/position path.
package quad_pkg;

    // Width of the decoder's wrapping count.
    localparam int COUNT_W = 8;

    // Default sample window: 1 kHz at a 50 MHz system clock.
    localparam int DEFAULT_WINDOW = 50000;

    // INIT captures the first count after reset; RUN produces samples.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } quad_state_t;

endpackage

// File: rtl/tick_gen.sv
// WINDOW-modulo timer. Produces a one-cycle tick on the last clock of
// each window while enabled; the count is held while disabled.
module tick_gen
    import quad_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

    logic [TW-1:0] r_timer;
    logic          w_last;

    assign w_last = (r_timer == TW'(WINDOW - 1));
    assign o_tick = i_enable & w_last;

    // Count 0..WINDOW-1 and wrap, only while enabled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_timer <= '0;
        end else if (i_enable) begin
            if (w_last) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_velocity.sv
// Converts the decoder's wrapping 8-bit count into a per-window signed
// velocity and a saturating signed absolute position.
module quad_velocity
    import quad_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int POS_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [COUNT_W-1:0] i_count,
    input  logic               i_clear,
    output logic [POS_W-1:0]   o_position,
    output logic [COUNT_W-1:0] o_velocity,
    output logic               o_sample_valid,
    output logic               o_overflow
);

    // Clamp limits of the signed position register.
    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    quad_state_t        r_state;
    logic [COUNT_W-1:0] r_prev;
    logic [COUNT_W-1:0] r_velocity;
    logic [POS_W-1:0]   r_position;
    logic               r_sample_valid;
    logic               r_overflow;

    logic               w_run;
    logic               w_tick;
    logic [COUNT_W-1:0] w_delta;
    logic [POS_W:0]     w_sum;
    logic               w_pos_ovf;
    logic               w_neg_ovf;
    logic [POS_W-1:0]   w_sat;

    assign w_run = (r_state == RUN);

    tick_gen #(
        .WINDOW (WINDOW)
    ) u_tick_gen (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (w_run),
        .o_tick   (w_tick)
    );

    // Modulo-256 difference; its two's-complement reading is the signed
    // movement since the previous sample.
    assign w_delta = i_count - r_prev;

    // One guard bit is enough: the sign of the sum disagreeing with the
    // top result bit means the true sum left the POS_W-bit range.
    assign w_sum     = {r_position[POS_W-1], r_position}
                     + {{(POS_W + 1 - COUNT_W){w_delta[COUNT_W-1]}}, w_delta};
    assign w_pos_ovf = ~w_sum[POS_W] &  w_sum[POS_W-1];
    assign w_neg_ovf =  w_sum[POS_W] & ~w_sum[POS_W-1];
    assign w_sat     = w_pos_ovf ? POS_MAX :
                       w_neg_ovf ? POS_MIN : w_sum[POS_W-1:0];

    // Control FSM plus sample/accumulate datapath; clear beats a
    // coincident tick for position/overflow only.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= INIT;
            r_prev         <= '0;
            r_velocity     <= '0;
            r_position     <= '0;
            r_sample_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_prev         <= i_count;
                    r_sample_valid <= 1'b0;
                    r_state        <= RUN;
                end
                RUN: begin
                    r_sample_valid <= w_tick;
                    if (w_tick) begin
                        r_prev     <= i_count;
                        r_velocity <= w_delta;
                    end
                    if (i_clear) begin
                        r_position <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_tick) begin
                        r_position <= w_sat;
                        if (w_pos_ovf || w_neg_ovf) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign o_position     = r_position;
    assign o_velocity     = r_velocity;
    assign o_sample_valid = r_sample_valid;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_quad_velocity.sv
// Bench for quad_velocity: two instances (16-bit and 9-bit position) share
// stimulus; a window-level integer model predicts every sample.
module tb_quad_velocity;

    localparam int WIN = 4;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic [7:0] i_count = 8'd0;
    logic       i_clear = 1'b0;

    logic [15:0] pos16;
    logic [8:0]  pos9;
    logic [7:0]  vel16, vel9;
    logic        valid16, valid9, ov16, ov9;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (plain integers, per-window view)
    logic [7:0] m_prev = 8'd0;
    int         m_vel  = 0;
    int         m_pos16 = 0, m_pos9 = 0;
    bit         m_ov16 = 0, m_ov9 = 0;

    always #5 i_clk = ~i_clk;

    quad_velocity #(.WINDOW(WIN), .POS_W(16)) dut16 (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_count        (i_count),
        .i_clear        (i_clear),
        .o_position     (pos16),
        .o_velocity     (vel16),
        .o_sample_valid (valid16),
        .o_overflow     (ov16)
    );

    quad_velocity #(.WINDOW(WIN), .POS_W(9)) dut9 (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_count        (i_count),
        .i_clear        (i_clear),
        .o_position     (pos9),
        .o_velocity     (vel9),
        .o_sample_valid (valid9),
        .o_overflow     (ov9)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Apply one window's worth of movement to a saturating integer position.
    function automatic int accumulate(input int pos, input int d, input int w, inout bit ov);
        int lim = 1 << (w - 1);
        int s = pos + d;
        if (s > lim - 1) begin s = lim - 1; ov = 1; end
        if (s < -lim)    begin s = -lim;    ov = 1; end
        return s;
    endfunction

    // INIT edge after reset release: captures count, never samples.
    task automatic do_init();
        step();
        m_prev = i_count;
        m_vel = 0; m_pos16 = 0; m_pos9 = 0; m_ov16 = 0; m_ov9 = 0;
        n_cmp++;
        if (valid16 !== 1'b0 || valid9 !== 1'b0) begin
            n_fail++;
            $display("FAIL init_no_sample: valid16=%b valid9=%b required 0", valid16, valid9);
        end
    endtask

    // Run one full window; count moves to new_c somewhere inside it.
    task automatic run_window(input logic [7:0] new_c, input bit clr_tick, input bit clr_mid, input string tag);
        int change_at = $urandom_range(1, WIN);
        logic [7:0] d8;
        int d;
        for (int e = 1; e <= WIN; e++) begin
            if (e == change_at) i_count = new_c;
            if (e == 1 && clr_mid) i_clear = 1'b1;
            else if (e == WIN)     i_clear = clr_tick;
            else                   i_clear = 1'b0;
            step();
            if (e < WIN) begin
                if (e == 1 && clr_mid) begin
                    m_pos16 = 0; m_pos9 = 0; m_ov16 = 0; m_ov9 = 0;
                    n_cmp++;
                    if (pos16 !== 16'd0 || pos9 !== 9'd0 || ov16 !== 1'b0 || ov9 !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s mid_clear: pos16=%0d pos9=%0d ov16=%b ov9=%b required 0", tag, pos16, pos9, ov16, ov9);
                    end
                end
                n_cmp++;
                if (valid16 !== 1'b0 || valid9 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s no_pulse_edge%0d: valid16=%b valid9=%b required 0", tag, e, valid16, valid9);
                end
            end else begin
                d8 = new_c - m_prev;
                d = int'($signed(d8));
                m_prev = new_c;
                m_vel = d;
                if (clr_tick) begin
                    m_pos16 = 0; m_pos9 = 0; m_ov16 = 0; m_ov9 = 0;
                end else begin
                    m_pos16 = accumulate(m_pos16, d, 16, m_ov16);
                    m_pos9  = accumulate(m_pos9, d, 9, m_ov9);
                end
                n_cmp++;
                if (valid16 !== 1'b1 || valid9 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s pulse: valid16=%b valid9=%b required 1", tag, valid16, valid9);
                end
                n_cmp++;
                if (int'($signed(vel16)) != m_vel || int'($signed(vel9)) != m_vel) begin
                    n_fail++;
                    $display("FAIL %s velocity: got %0d/%0d required %0d", tag, $signed(vel16), $signed(vel9), m_vel);
                end
                n_cmp++;
                if (int'($signed(pos16)) != m_pos16 || ov16 !== m_ov16) begin
                    n_fail++;
                    $display("FAIL %s pos16: got %0d ov %b required %0d ov %b", tag, $signed(pos16), ov16, m_pos16, m_ov16);
                end
                n_cmp++;
                if (int'($signed(pos9)) != m_pos9 || ov9 !== m_ov9) begin
                    n_fail++;
                    $display("FAIL %s pos9: got %0d ov %b required %0d ov %b", tag, $signed(pos9), ov9, m_pos9, m_ov9);
                end
                $display("window %s: count=%0d vel=%0d pos16=%0d pos9=%0d ov9=%b", tag, new_c, $signed(vel16), $signed(pos16), $signed(pos9), ov9);
            end
        end
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        i_count = 8'd200;
        step();
        n_cmp++;
        if (pos16 !== 16'd0 || vel16 !== 8'd0 || valid16 !== 1'b0 || ov16 !== 1'b0 ||
            pos9 !== 9'd0 || vel9 !== 8'd0 || valid9 !== 1'b0 || ov9 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pos16=%0d vel=%0d valid=%b ov=%b required all 0", pos16, vel16, valid16, ov16);
        end
        i_reset = 1'b0;
        do_init();
        run_window(8'd200, 1'b0, 1'b0, "first");
    endtask

    task automatic test_wrap();
        run_window(8'd250, 1'b0, 1'b0, "to250");
        run_window(8'd4,   1'b0, 1'b0, "wrap_up");
        run_window(8'd250, 1'b0, 1'b0, "wrap_dn");
    endtask

    task automatic test_saturate();
        run_window(m_prev, 1'b0, 1'b1, "pre_clr");
        for (int k = 0; k < 3; k++) run_window(m_prev + 8'd100, 1'b0, 1'b0, "plus100");
        run_window(m_prev, 1'b0, 1'b1, "post_clr");
    endtask

    task automatic test_clear_on_tick();
        run_window(m_prev + 8'd7, 1'b1, 1'b0, "clr_tick");
    endtask

    task automatic test_reset_mid();
        run_window(m_prev + 8'd50, 1'b0, 1'b0, "to50");
        step();
        i_count = i_count + 8'd33;
        step();
        i_reset = 1'b1;
        #1;
        n_cmp++;
        if (pos16 !== 16'd0 || vel16 !== 8'd0 || valid16 !== 1'b0 || ov16 !== 1'b0 ||
            pos9 !== 9'd0 || vel9 !== 8'd0 || valid9 !== 1'b0 || ov9 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pos16=%0d vel=%0d pos9=%0d required all 0", pos16, vel16, pos9);
        end
        step();
        i_reset = 1'b0;
        do_init();
        run_window(m_prev, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_steady();
        for (int k = 0; k < 100; k++) begin
            int d = int'($urandom_range(0, 254)) - 127;
            bit cm = ($urandom_range(0, 15) == 0);
            run_window(m_prev + 8'(d), 1'b0, cm, "steady");
        end
        step();
        n_cmp++;
        if (valid16 !== 1'b0 || valid9 !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width: valid16=%b valid9=%b required 0", valid16, valid9);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_clear_on_tick();
        test_reset_mid();
        test_steady();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
